// File: rtl/comp_share_nibble_acc.sv
// Serial nibble multiplier front-end: issues coef nibbles (LSB first) to the shared base block
// and accumulates the shifted, sign-extended partial products into a full signed product.
module comp_share_nibble_acc #(
    parameter int IN_DATA_WIDTH = 17,
    parameter int PP_WIDTH      = 21,
    parameter int COEF_WIDTH    = 16,
    parameter int ACC_WIDTH     = 33
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [IN_DATA_WIDTH-1:0] in_data,
    input  logic [COEF_WIDTH-1:0]    coef,
    output logic                     busy,
    output logic [IN_DATA_WIDTH-1:0] pp_in_data,
    output logic [3:0]               pp_polynomial,
    output logic                     pp_req,
    input  logic [PP_WIDTH-1:0]      pp_data,
    input  logic                     pp_vld,
    output logic [ACC_WIDTH-1:0]     product,
    output logic                     product_vld
);

    localparam int NIB = COEF_WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [KW-1:0]           k;
    logic [COEF_WIDTH-1:0]   coef_l;
    logic [ACC_WIDTH-1:0]    acc;

    function automatic logic [3:0] nibble_of(input logic [COEF_WIDTH-1:0] c,
                                             input logic [KW-1:0]         idx);
        logic [COEF_WIDTH-1:0] s;
        s = c >> {idx, 2'b00};
        return s[3:0];
    endfunction

    // Partial product weight is 16^k; sign-extend first so negative samples shift correctly.
    function automatic logic [ACC_WIDTH-1:0] scaled_pp(input logic [PP_WIDTH-1:0] pp,
                                                       input logic [KW-1:0]       idx);
        logic [ACC_WIDTH-1:0] ext;
        ext = {{(ACC_WIDTH-PP_WIDTH){pp[PP_WIDTH-1]}}, pp};
        return ext << {idx, 2'b00};
    endfunction

    // Sequencer: one nibble outstanding at a time, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            k             <= '0;
            coef_l        <= '0;
            acc           <= '0;
            product       <= '0;
            pp_in_data    <= '0;
            pp_polynomial <= 4'd0;
            busy          <= 1'b0;
            pp_req        <= 1'b0;
            product_vld   <= 1'b0;
        end else begin
            pp_req      <= 1'b0;
            product_vld <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is still high in the cycle after DONE, which blocks a start there
                    if (start && !busy) begin
                        coef_l        <= coef;
                        pp_in_data    <= in_data;
                        pp_polynomial <= coef[3:0];
                        acc           <= '0;
                        k             <= '0;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    pp_req <= 1'b1;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (pp_vld) begin
                        acc <= acc + scaled_pp(pp_data, k);
                        if (k == KW'(NIB - 1)) begin
                            state <= DONE;
                        end else begin
                            k             <= k + KW'(1'b1);
                            pp_polynomial <= nibble_of(coef_l, k + KW'(1'b1));
                            state         <= ISSUE;
                        end
                    end else begin
                        state <= WAIT;
                    end
                end
                DONE: begin
                    product     <= acc;
                    product_vld <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_share_nibble_acc.sv
// Directed bench for comp_share_nibble_acc with a 2-cycle base-block model (pp = in_data * nibble).
module tb_comp_share_nibble_acc;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [16:0] in_data;
    logic [15:0] coef;
    logic        busy;
    logic [16:0] pp_in_data;
    logic [3:0]  pp_polynomial;
    logic        pp_req;
    logic [20:0] pp_data;
    logic        pp_vld;
    logic [32:0] product;
    logic        product_vld;

    logic        inj_vld;
    logic        req_d1 = 1'b0;
    logic        req_d2 = 1'b0;
    logic [20:0] pp_d1  = 21'd0;
    logic [20:0] pp_d2  = 21'd0;
    logic [3:0]  poly_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    comp_share_nibble_acc dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .coef         (coef),
        .busy         (busy),
        .pp_in_data   (pp_in_data),
        .pp_polynomial(pp_polynomial),
        .pp_req       (pp_req),
        .pp_data      (pp_data),
        .pp_vld       (pp_vld),
        .product      (product),
        .product_vld  (product_vld)
    );

    always #5 clk = ~clk;

    // Base-block model: result appears two cycles after the request pulse.
    always @(posedge clk) begin
        req_d1 <= pp_req;
        req_d2 <= req_d1;
        pp_d1  <= 21'(int'($signed(pp_in_data)) * int'(pp_polynomial));
        pp_d2  <= pp_d1;
    end

    assign pp_vld  = req_d2 | inj_vld;
    assign pp_data = inj_vld ? 21'h0ABCD : pp_d2;

    always @(negedge clk) begin
        if (pp_req === 1'b1) poly_q.push_back(pp_polynomial);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One multiply; optional stray start / stray pp_vld at a given cycle after acceptance.
    task automatic run_mul(input string tag, input logic [16:0] a, input logic [15:0] c,
                           input int spur_cyc, input int inj_cyc);
        logic [32:0] exp_p;
        int          lat;
        bit          seen;
        logic [15:0] cw;
        exp_p = 33'(longint'($signed(a)) * longint'(c));
        poly_q.delete();
        @(negedge clk);
        in_data = a;
        coef    = c;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        in_data = 17'h1F0F0;
        coef    = 16'hA5A5;
        lat     = 1;
        seen    = 1'b0;
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        while (lat < 60) begin
            start   = (lat == spur_cyc);
            inj_vld = (lat == inj_cyc);
            if (product_vld === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(lat - 1), 64'd17);
        check({tag, "_product"}, 64'(product), 64'(exp_p));
        @(negedge clk);
        start   = 1'b0;
        inj_vld = 1'b0;
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
        check({tag, "_vld_pulse"}, 64'(product_vld), 64'd0);
        @(negedge clk);
        check({tag, "_idle_hold"}, 64'(busy), 64'd0);
        check({tag, "_product_hold"}, 64'(product), 64'(exp_p));
        check({tag, "_poly_count"}, 64'(poly_q.size()), 64'd4);
        cw = c;
        for (int i = 0; i < 4; i++) begin
            if (i < poly_q.size()) check({tag, "_poly"}, 64'(poly_q[i]), 64'(cw[3:0]));
            cw = cw >> 4;
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        inj_vld = 1'b0;
        in_data = 17'd0;
        coef    = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req", 64'(pp_req), 64'd0);
        check("rst_pvld", 64'(product_vld), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_poly", 64'(pp_polynomial), 64'd0);
        check("rst_indata", 64'(pp_in_data), 64'd0);
        reset = 1'b0;

        run_mul("t1", 17'd5, 16'h0001, -1, -1);
        run_mul("t2", 17'h1FFFD, 16'h1234, -1, -1);
        run_mul("t3", 17'd65535, 16'hFFFF, -1, -1);
        // stray start in WAIT, then stray start on the product_vld cycle, then back-to-back
        run_mul("t4", 17'd100, 16'h0F0F, 3, -1);
        run_mul("t4b", 17'h1FFF9, 16'h8001, 18, -1);
        run_mul("t4c", 17'd321, 16'h0000, -1, -1);

        @(negedge clk);
        inj_vld = 1'b1;
        @(negedge clk);
        inj_vld = 1'b0;
        check("t5_idle_vld", 64'(product), 64'd0);
        run_mul("t5", 17'd1234, 16'h00A0, -1, 1);

        @(negedge clk);
        in_data = 17'd77;
        coef    = 16'h4321;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_req", 64'(pp_req), 64'd0);
        check("t6_pvld", 64'(product_vld), 64'd0);
        check("t6_product", 64'(product), 64'd0);
        check("t6_poly", 64'(pp_polynomial), 64'd0);
        check("t6_indata", 64'(pp_in_data), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        run_mul("t6", 17'h10000, 16'hFFFF, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
